// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard sequencer and the decoder that feeds it.
package hazard_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } hazard_state_t;

    // Hard-wired zero register; a load to x0 never creates a dependency
    localparam logic [4:0] REG_X0 = 5'd0;

    // RV32I major opcodes used to derive ex_is_load and mem_req upstream
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    // Count up on inc, stick at all-ones, clear on reset or clr
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, EX redirects,
// whole-pipeline freeze on slow data memory, timeout fault and statistics.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             stat_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                WAIT_W    = 16;
    // Fault fires when the incremented wait count would reach this value,
    // i.e. after MEM_TIMEOUT consecutive frozen cycles including the RUN one.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hazard_state_t     state_reg;
    logic [WAIT_W-1:0] wait_reg;
    logic [WAIT_W-1:0] wait_next;
    logic              fault_reg;
    logic              freeze;
    logic              load_use;
    logic              stall_inc;
    logic              flush_inc;

    assign freeze    = mem_req & ~mem_ready;
    assign wait_next = wait_reg + 1'b1;
    assign load_use  = ex_is_load && (ex_rd != REG_X0) &&
                       ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                        (id_uses_rs2 && (id_rs2 == ex_rd)));

    // Combinational pipeline controls, priority: reset, fault, freeze, redirect, load-use
    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_write = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (!rst_n) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (state_reg == FAULT) begin
            // everything held until reset
        end else if (freeze) begin
            // redirect, if any, stays in EX and is applied once memory completes
            stall_inc = 1'b1;
        end else if (ex_redirect) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_write  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_write = 1'b1;
            mem_wb_write = 1'b1;
            flush_inc    = 1'b1;
        end else if (load_use) begin
            // hold PC and IF/ID, insert one bubble; older stages keep moving
            id_ex_write  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_write = 1'b1;
            mem_wb_write = 1'b1;
            stall_inc    = 1'b1;
        end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            mem_wb_write = 1'b1;
        end
    end

    // Sequencer state, memory wait timer and sticky fault flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= RUN;
            wait_reg  <= '0;
            fault_reg <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    wait_reg <= '0;
                    if (freeze) begin
                        state_reg <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (!freeze) begin
                        state_reg <= RUN;
                        wait_reg  <= '0;
                    end else begin
                        wait_reg <= wait_next;
                        if (wait_next == WAIT_LAST) begin
                            state_reg <= FAULT;
                            fault_reg <= 1'b1;
                        end
                    end
                end
                FAULT: begin
                    state_reg <= FAULT;
                end
                default: begin
                    state_reg <= RUN;
                    wait_reg  <= '0;
                end
            endcase
        end
    end

    assign mem_fault = fault_reg;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a
// randomized run against a behavioural reference model.
module tb_pipeline_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 2;

    localparam logic [6:0] CTL_RESET  = 7'b0010100;
    localparam logic [6:0] CTL_FROZEN = 7'b0000000;
    localparam logic [6:0] CTL_REDIR  = 7'b1111111;
    localparam logic [6:0] CTL_BUBBLE = 7'b0001111;
    localparam logic [6:0] CTL_NORMAL = 7'b1101011;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_is_load, ex_redirect;
    logic          mem_req, mem_ready, stat_clr;
    logic          pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic          ex_mem_write, mem_wb_write, mem_fault;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [6:0]    ctl;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit            m_fault;
    int            m_frozen;
    logic [CW-1:0] m_stall;
    logic [CW-1:0] m_flush;

    always #5 clk = ~clk;

    assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                  ex_mem_write, mem_wb_write};

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rd        (ex_rd),
        .ex_is_load   (ex_is_load),
        .ex_redirect  (ex_redirect),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .stat_clr     (stat_clr),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_write  (id_ex_write),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_write (ex_mem_write),
        .mem_wb_write (mem_wb_write),
        .mem_fault    (mem_fault),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    function automatic bit m_load_use();
        return ex_is_load && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    endfunction

    // Expected controls from the hazard rules and the model's fault flag
    function automatic logic [6:0] exp_ctl();
        if (!rst_n)                        return CTL_RESET;
        if (m_fault)                       return CTL_FROZEN;
        if (mem_req && !mem_ready)         return CTL_FROZEN;
        if (ex_redirect)                   return CTL_REDIR;
        if (m_load_use())                  return CTL_BUBBLE;
        return CTL_NORMAL;
    endfunction

    task automatic idle();
        rst_n = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_is_load = 1'b0;
        ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; stat_clr = 1'b0;
    endtask

    task automatic set_load_use();
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    endtask

    // Advance one clock, updating the reference model with the current inputs
    task automatic tick();
        bit s_inc;
        bit f_inc;
        s_inc = 1'b0;
        f_inc = 1'b0;
        if (!rst_n) begin
            m_fault = 1'b0; m_frozen = 0; m_stall = '0; m_flush = '0;
        end else begin
            if (!m_fault) begin
                if (mem_req && !mem_ready) begin
                    s_inc = 1'b1;
                    m_frozen++;
                    if (m_frozen >= TO) m_fault = 1'b1;
                end else begin
                    m_frozen = 0;
                    if (ex_redirect)       f_inc = 1'b1;
                    else if (m_load_use()) s_inc = 1'b1;
                end
            end
            if (stat_clr) begin
                m_stall = '0; m_flush = '0;
            end else begin
                if (s_inc && m_stall != '1) m_stall = m_stall + 1'b1;
                if (f_inc && m_flush != '1) m_flush = m_flush + 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        ex_redirect = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== CTL_RESET) begin
            errors++; $display("FAIL reset_ctl got %b want %b", ctl, CTL_RESET);
        end
        tick();
        checks++;
        if (stall_cnt !== 2'd0 || flush_cnt !== 2'd0 || mem_fault !== 1'b0) begin
            errors++; $display("FAIL reset_state got stall=%0d flush=%0d fault=%b want 0 0 0",
                               stall_cnt, flush_cnt, mem_fault);
        end
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        apply_reset();
        set_load_use();
        @(negedge clk);
        checks++;
        if (ctl !== CTL_BUBBLE) begin
            errors++; $display("FAIL load_use_ctl got %b want %b", ctl, CTL_BUBBLE);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (ctl !== CTL_NORMAL) begin
            errors++; $display("FAIL load_use_one_cycle got %b want %b", ctl, CTL_NORMAL);
        end
        checks++;
        if (stall_cnt !== 2'd1) begin
            errors++; $display("FAIL load_use_stall_cnt got %0d want 1", stall_cnt);
        end
        tick();
        $display("test_load_use done");
    endtask

    task automatic test_x0();
        apply_reset();
        ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== CTL_NORMAL) begin
            errors++; $display("FAIL x0_ctl got %b want %b", ctl, CTL_NORMAL);
        end
        tick();
        checks++;
        if (stall_cnt !== 2'd0) begin
            errors++; $display("FAIL x0_stall_cnt got %0d want 0", stall_cnt);
        end
        $display("test_x0 done");
    endtask

    task automatic test_redirect_beats_load_use();
        apply_reset();
        set_load_use();
        ex_redirect = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== CTL_REDIR) begin
            errors++; $display("FAIL redirect_ctl got %b want %b", ctl, CTL_REDIR);
        end
        tick();
        checks++;
        if (flush_cnt !== 2'd1 || stall_cnt !== 2'd0) begin
            errors++; $display("FAIL redirect_cnts got flush=%0d stall=%0d want 1 0",
                               flush_cnt, stall_cnt);
        end
        $display("test_redirect_beats_load_use done");
    endtask

    task automatic test_mem_wait_redirect();
        apply_reset();
        mem_req = 1'b1; mem_ready = 1'b0; ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ctl !== CTL_FROZEN) begin
                errors++; $display("FAIL memwait_frozen cyc%0d got %b want %b", i, ctl, CTL_FROZEN);
            end
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== CTL_REDIR) begin
            errors++; $display("FAIL memwait_release got %b want %b", ctl, CTL_REDIR);
        end
        tick();
        checks++;
        if (flush_cnt !== 2'd1 || stall_cnt !== 2'd3 || mem_fault !== 1'b0) begin
            errors++; $display("FAIL memwait_cnts got flush=%0d stall=%0d fault=%b want 1 3 0",
                               flush_cnt, stall_cnt, mem_fault);
        end
        idle();
        mem_req = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== CTL_FROZEN) begin
            errors++; $display("FAIL memwait_back_in_run got %b want %b", ctl, CTL_FROZEN);
        end
        tick();
        mem_ready = 1'b1;
        tick();
        $display("test_mem_wait_redirect done");
    endtask

    task automatic test_timeout_reset();
        apply_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            tick();
            checks++;
            if (mem_fault !== (i == TO)) begin
                errors++; $display("FAIL timeout_fault cyc%0d got %b want %b", i, mem_fault, (i == TO));
            end
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== CTL_FROZEN) begin
            errors++; $display("FAIL fault_hold_ctl got %b want %b", ctl, CTL_FROZEN);
        end
        tick();
        checks++;
        if (mem_fault !== 1'b1) begin
            errors++; $display("FAIL fault_sticky got %b want 1", mem_fault);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (mem_fault !== 1'b0 || stall_cnt !== 2'd0 || flush_cnt !== 2'd0) begin
            errors++; $display("FAIL fault_reset got fault=%b stall=%0d flush=%0d want 0 0 0",
                               mem_fault, stall_cnt, flush_cnt);
        end
        idle();
        @(negedge clk);
        checks++;
        if (ctl !== CTL_NORMAL) begin
            errors++; $display("FAIL fault_reset_run got %b want %b", ctl, CTL_NORMAL);
        end
        tick();
        $display("test_timeout_reset done");
    endtask

    task automatic test_saturation_clear();
        apply_reset();
        set_load_use();
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (stall_cnt !== 2'd3) begin
            errors++; $display("FAIL sat_hold got %0d want 3", stall_cnt);
        end
        stat_clr = 1'b1;
        tick();
        checks++;
        if (stall_cnt !== 2'd0) begin
            errors++; $display("FAIL clr_priority got %0d want 0", stall_cnt);
        end
        idle();
        $display("test_saturation_clear done");
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            rst_n       = ($urandom_range(0, 99) >= 2);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_uses_rs1 = 1'($urandom_range(0, 1));
            id_uses_rs2 = 1'($urandom_range(0, 1));
            ex_is_load  = 1'($urandom_range(0, 1));
            ex_redirect = ($urandom_range(0, 3) == 0);
            mem_req     = ($urandom_range(0, 2) == 0);
            mem_ready   = ($urandom_range(0, 2) == 0);
            stat_clr    = ($urandom_range(0, 29) == 0);
            @(negedge clk);
            checks++;
            if (ctl !== exp_ctl()) begin
                errors++; $display("FAIL rand_ctl n=%0d got %b want %b", n, ctl, exp_ctl());
            end
            tick();
            checks++;
            if (stall_cnt !== m_stall || flush_cnt !== m_flush || mem_fault !== m_fault) begin
                errors++; $display("FAIL rand_state n=%0d got stall=%0d flush=%0d fault=%b want %0d %0d %b",
                                   n, stall_cnt, flush_cnt, mem_fault, m_stall, m_flush, m_fault);
            end
        end
        idle();
        $display("test_random done");
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        m_fault = 1'b0; m_frozen = 0; m_stall = '0; m_flush = '0;
        test_reset();
        test_load_use();
        test_x0();
        test_redirect_beats_load_use();
        test_mem_wait_redirect();
        test_timeout_reset();
        test_saturation_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Detects load-use hazards, applies control-flow redirects from EX, and freezes the whole pipeline while the data memory has not completed.
- Drives the write enables and bubble/flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Keeps saturating stall and flush statistics, and raises a sticky fault on data-memory timeout.

Parameters:
- MEM_TIMEOUT, 64: consecutive MEM_WAIT cycles before entering FAULT; legal range 2..65535.
- CNT_W, 16: width of each statistics counter.

Ports:
- clk in 1: pipeline clock.
- rst_n in 1: reset. One clock; reset is synchronous and active-low.
- id_rs1 in 5: rs1 index of the instruction in ID.
- id_rs2 in 5: rs2 index of the instruction in ID.
- id_uses_rs1 in 1: the ID instruction reads rs1.
- id_uses_rs2 in 1: the ID instruction reads rs2.
- ex_rd in 5: destination index of the instruction in EX.
- ex_is_load in 1: the EX instruction is a load.
- ex_redirect in 1: EX resolved a taken branch, jal or jalr.
- mem_req in 1: the MEM instruction is a load or store.
- mem_ready in 1: data memory completes the access this cycle.
- stat_clr in 1: synchronous clear of both statistics counters.
- pc_write out 1: PC register enable.
- if_id_write out 1: IF/ID enable.
- if_id_flush out 1: IF/ID loads a NOP.
- id_ex_write out 1: ID/EX enable.
- id_ex_flush out 1: ID/EX loads a bubble.
- ex_mem_write out 1: EX/MEM enable.
- mem_wb_write out 1: MEM/WB enable.
- mem_fault out 1: sticky timeout flag.
- stall_cnt out CNT_W: cycles with pc_write=0 while in RUN or MEM_WAIT.
- flush_cnt out CNT_W: number of redirects applied.

Behaviour:
- States: RUN, MEM_WAIT, FAULT. State and counters are registered; all control outputs are combinational from state and current inputs, so they take effect on the same edge.
- Reset (rst_n=0 at an edge): state<=RUN, wait_cnt<=0, stall_cnt<=0, flush_cnt<=0, mem_fault<=0.
- While rst_n=0, outputs are forced to: all *_write=0, if_id_flush=1, id_ex_flush=1.
- Reset asserted mid-MEM_WAIT or in FAULT returns to RUN the next cycle; no state survives.
- freeze = mem_req & !mem_ready.
  - In RUN or MEM_WAIT with freeze=1: every *_write=0 and both flushes=0.
  - A redirect present during a freeze is ignored; it is applied on the cycle freeze drops, because the branch is held in EX.
- RUN to MEM_WAIT when freeze=1.
- In MEM_WAIT:
  - wait_cnt increments each cycle.
  - mem_ready=1 releases: advance normally that cycle, state<=RUN, wait_cnt<=0.
  - If wait_cnt reaches MEM_TIMEOUT-1 while still frozen: state<=FAULT, mem_fault<=1.
- FAULT: all *_write=0, flushes=0, counters hold. The only exit is reset.
- No freeze, priority order (first match wins):
  1. ex_redirect: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_write=1, id_ex_flush=1; flush_cnt+1. A simultaneous load-use condition is discarded, since the ID instruction is wrong-path.
  2. load_use = ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
     - pc_write=0, if_id_write=0, id_ex_write=1, id_ex_flush=1.
     - One cycle only: the next cycle the load is in MEM and forwarding resolves the dependency.
  3. Otherwise: all *_write=1, flushes=0.
- ex_mem_write and mem_wb_write are 0 only on freeze or FAULT; a load-use bubble does not stop them.
- Counters:
  - Both saturate at all-ones and never wrap.
  - stat_clr has priority over increment in the same cycle.
  - stall_cnt increments on load-use and freeze cycles.

Decomposition:
- Shared package hazard_pkg holds:
  - State enum: RUN=2'd0, MEM_WAIT=2'd1, FAULT=2'd2.
  - REG_X0=5'd0.
  - RV32I opcode constants (OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_BRANCH=7'b1100011, OP_JAL=7'b1101111, OP_JALR=7'b1100111), shared with the decoder that produces ex_is_load and mem_req.
- One sub-module, sat_counter (params W; inputs clk, rst_n, clr, inc; output count), instantiated twice.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 for exactly 1 cycle; stall_cnt=1.
- x0 exemption: ex_is_load=1, ex_rd=0, id_rs1=0, id_uses_rs1=1 -> no stall; all *_write=1; stall_cnt=0.
- Redirect beats load-use: ex_redirect=1 with the load-use pattern above -> pc_write=1, if_id_flush=1, id_ex_flush=1; flush_cnt=1; stall_cnt=0.
- Memory wait plus redirect: mem_req=1, mem_ready=0 for 3 cycles, ex_redirect=1 throughout -> 3 cycles of all *_write=0 with no flushes. On the mem_ready=1 cycle: flushes=1, pc_write=1, state=RUN, flush_cnt=1, stall_cnt=3.
- Timeout and reset: MEM_TIMEOUT=4, mem_req=1, mem_ready=0 held -> mem_fault=1 after cycle 4; writes stay 0 even after mem_ready=1. rst_n=0 for 1 cycle -> mem_fault=0, state=RUN, counters=0.
- Saturation and clear: CNT_W=2, 5 consecutive load-use cycles -> stall_cnt=3 held. stat_clr=1 together with a stall -> stall_cnt=0.
